// File: rtl/sram_pkg.sv
// Shared sizing and FSM encoding for the SRAM-backed FIFO controller.
package sram_pkg;
  localparam int DEPTH = 16;
  localparam int DW    = 4;
  localparam int AW    = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;
endpackage

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller in front of an external single-port 16x4 SRAM.
// Each SRAM access takes one cycle and is always followed by an IDLE cycle.
// A round-robin bit arbitrates when a write and a read are offered together.
module sram_fifo_ctrl import sram_pkg::*; #(
  parameter int DEPTH = sram_pkg::DEPTH,
  parameter int DW    = sram_pkg::DW,
  parameter int AW    = sram_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic          rd_req,
  output logic          rd_grant,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [DW-1:0] sram_inp,
  output logic [AW-1:0] sram_addr,
  output logic          sram_cs,
  output logic          sram_we,
  input  logic [DW-1:0] sram_outp
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          rr_wr;      // 1: write wins a tie next time
  logic          wr_elig, rd_elig, rd_win;

  // Read wins only if it is eligible and either no write competes or it is read's turn.
  assign wr_elig = wr_valid && !full;
  assign rd_elig = rd_req && !empty;
  assign rd_win  = rd_elig && (!wr_elig || !rr_wr);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and the two combinational handshake outputs.
  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    rd_grant  = 1'b0;
    case (state)
      IDLE: begin
        rd_grant = rd_win;
        wr_ready = !full && !rd_win;
        if (wr_ready && wr_valid) state_nxt = WR;
        else if (rd_grant)        state_nxt = RD;
      end
      WR:      state_nxt = IDLE;
      RD:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered SRAM port, pointers, occupancy and read-return path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_addr <= '0;
      sram_inp  <= '0;
      rr_wr     <= 1'b1;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ready && wr_valid) begin
            sram_cs   <= 1'b1;
            sram_we   <= 1'b1;
            sram_addr <= wr_ptr;
            sram_inp  <= wr_data;
            rr_wr     <= 1'b0;
          end else if (rd_grant) begin
            sram_cs   <= 1'b1;
            sram_we   <= 1'b0;
            sram_addr <= rd_ptr;
            rr_wr     <= 1'b1;
          end
        end
        WR: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
          wr_ptr  <= wr_ptr + 1'b1;
          count   <= count + 1'b1;
          full    <= (count + 1'b1) == FULL_CNT;
          empty   <= 1'b0;
        end
        RD: begin
          sram_cs  <= 1'b0;
          sram_we  <= 1'b0;
          rd_data  <= sram_outp;
          rd_valid <= 1'b1;
          rd_ptr   <= rd_ptr + 1'b1;
          count    <= count - 1'b1;
          full     <= 1'b0;
          empty    <= count == ONE_CNT;
        end
        default: begin
          sram_cs <= 1'b0;
          sram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of external SRAM words; fixed at 16 for the cascaded 16x4 SRAM.
REQ-002 Parameter DW, default 4, data width; AW, default 4, address width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 wr_valid  input  1  producer offers wr_data.
REQ-007 wr_data  input  DW  word to enqueue.
REQ-008 wr_ready  output  1  write accepted when wr_valid&&wr_ready at a rising edge.
REQ-009 rd_req  input  1  consumer requests one word.
REQ-010 rd_grant  output  1  read request accepted this cycle.
REQ-011 rd_data  output  DW  dequeued word, valid while rd_valid.
REQ-012 rd_valid  output  1  one-cycle pulse, rd_data valid.
REQ-013 full / empty  output  1 each  occupancy flags.
REQ-014 count  output  AW+1  words stored, 0..16.
REQ-015 sram_inp, sram_addr  output  DW, AW  SRAM data-in and address.
REQ-016 sram_cs, sram_we  output  1 each  SRAM chip select, write enable.
REQ-017 sram_outp  input  DW  SRAM combinational read data.

Function
REQ-018 FSM states IDLE, WR, RD; every SRAM access SHALL last exactly one cycle, then return to IDLE (max one op per two cycles).
REQ-019 In IDLE: wr_ready = !full && write granted; rd_grant = rd_req && !empty && read granted; never both.
REQ-020 Both eligible in IDLE: grant the kind not served last (round-robin bit, reset favours write).
REQ-021 Write handshake at edge N: wr_data latched, state WR for cycle N+1 with sram_cs=1, sram_we=1, sram_addr=wr_ptr, sram_inp=latched data.
REQ-022 At end of WR: wr_ptr increments modulo 16 (15->0), count increments.
REQ-023 Read grant at edge N: state RD for cycle N+1 with sram_cs=1, sram_we=0, sram_addr=rd_ptr.
REQ-024 At end of RD: rd_data <= sram_outp, rd_valid=1 for cycle N+2 only, rd_ptr increments modulo 16, count decrements.
REQ-025 rd_data SHALL hold its last value until the next read completes.
REQ-026 In IDLE sram_cs=0, sram_we=0, sram_addr and sram_inp hold last values.
REQ-027 full = (count==16); empty = (count==0); writes when full and reads when empty SHALL be refused, no pointer or count change.
REQ-028 All outputs except wr_ready/rd_grant SHALL be registered.

Reset
REQ-029 On rst: state IDLE, wr_ptr=rd_ptr=0, count=0, empty=1, full=0, rd_valid=0, rd_data=0, sram_cs=0, sram_we=0, sram_addr=0, sram_inp=0, round-robin favours write.
REQ-030 Reset during WR or RD SHALL abort the access immediately (sram_we drops asynchronously); SRAM contents are treated as discarded.

Structure
REQ-031 Package sram_pkg SHALL hold DEPTH, DW, AW and the state encoding (IDLE, WR, RD).
REQ-032 No sub-module; the SRAM instance lives outside this block and connects at the top level.

Verification
REQ-033 Bench SHALL instantiate sram_fifo_ctrl with the cascaded 16x4 SRAM behind it.
REQ-034 Write 0xA then read -> WR cycle addr=0 we=1 inp=0xA; rd_valid two cycles after grant, rd_data=0xA; count 1->0, empty=1.
REQ-035 Write 16 words 0..15 -> full=1, count=16 after last WR; 17th wr_valid sees wr_ready=0; read all 16 -> data 0..15 in order, empty=1.
REQ-036 Wrap: write 16, read 4, write 0x7,0x8,0x9,0xA -> writes at addr 0..3; subsequent reads return 4..15 then 0x7,0x8,0x9,0xA.
REQ-037 wr_valid and rd_req held together with count=3 -> grants alternate write, read, write...; count stays 3..4.
REQ-038 rst asserted during a WR cycle -> sram_we=0 same cycle; after release count=0, empty=1, a read request gets rd_grant=0.
